// File: rtl/lfsr_pkg.sv
// Shared types, seed constants and shift-rule helpers for the LFSR pair stepper and its decoder.
// Latency: none (package only).
// Backpressure: not applicable.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam logic [3:0] SEED_A_DEF   = 4'b1101;
    localparam logic [3:0] SEED_B_DEF   = 4'b1010;
    localparam int         TICK_DIV_DEF = 20_000_000;
    localparam int         STEPS_DEF    = 4;

    // Register A feeds back A[0] xnor A[2] into its MSB; period 6 from the default seed.
    function automatic logic [3:0] next_a(input logic [3:0] a);
        return {a[0] ^ ~a[2], a[3:1]};
    endfunction

    // Register B shifts in the bit A is about to drop, taken from the pre-shift A.
    function automatic logic [3:0] next_b(input logic [3:0] a, input logic [3:0] b);
        return {a[0], b[3:1]};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled clocks.
// Latency: tick is combinational from the count register (high while count == TICK_DIV-1).
// Backpressure: none; enable low freezes the count, clear forces it to zero and masks tick.
module tick_prescaler #(
    parameter int TICK_DIV = 20_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = enable && !clear && (count == LAST);

    // Count enabled clocks, wrapping after the terminal value; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_pair_stepper.sv
// Advances a coupled pair of 4-bit shift registers by STEPS shifts per prescaler tick and presents {A,B}.
// Latency: tick in cycle T -> out_valid from cycle T+STEPS+1; one shift per clock while busy.
// Backpressure: frame held stable while out_ready is low; ticks arriving while busy are dropped and flag overrun.
module lfsr_pair_stepper
    import lfsr_pkg::*;
#(
    parameter int         TICK_DIV = TICK_DIV_DEF,
    parameter int         STEPS    = STEPS_DEF,
    parameter logic [3:0] SEED_A   = SEED_A_DEF,
    parameter logic [3:0] SEED_B   = SEED_B_DEF,
    parameter bit         RELOAD   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       reseed,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] frame_cnt
);

    localparam logic [3:0] STEP_LAST = 4'(STEPS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] step_cnt;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic       tick;
    logic       last_step;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .clear  (reseed),
        .tick   (tick)
    );

    assign last_step = (step_cnt == STEP_LAST);
    assign out_valid = (state == PRESENT);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: tick starts a frame, STEPS shifts later it is presented; reseed always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick)      state_nxt = SHIFT;
            SHIFT:   if (last_step) state_nxt = PRESENT;
            PRESENT: if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
        if (reseed) begin
            state_nxt = IDLE;
        end
    end

    // Shift registers, output snapshot, step/frame counters and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a     <= SEED_A;
            reg_b     <= SEED_B;
            out_a     <= SEED_A;
            out_b     <= SEED_B;
            step_cnt  <= '0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else if (reseed) begin
            reg_a     <= SEED_A;
            reg_b     <= SEED_B;
            out_a     <= SEED_A;
            out_b     <= SEED_B;
            step_cnt  <= '0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        step_cnt <= '0;
                    end
                end
                SHIFT: begin
                    reg_a    <= next_a(reg_a);
                    reg_b    <= next_b(reg_a, reg_b);
                    step_cnt <= step_cnt + 4'd1;
                    // Snapshot the post-shift values so out_a/out_b only move on entry to PRESENT.
                    if (last_step) begin
                        out_a <= next_a(reg_a);
                        out_b <= next_b(reg_a, reg_b);
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        if (RELOAD) begin
                            reg_a <= SEED_A;
                            reg_b <= SEED_B;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_pair_stepper.sv
// Scoreboard bench: two instances (STEPS=4/RELOAD=1 and STEPS=1/RELOAD=0), TICK_DIV=4.
// Expected frames are queued before each run and popped on every accepted handshake.
// Inputs change 1 ns after the rising edge; the monitors sample on the falling edge.
module tb_lfsr_pair_stepper;
    import lfsr_pkg::*;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n, enable, reseed, out_ready;
    logic       out_valid, busy, overrun;
    logic [3:0] out_a, out_b;
    logic [7:0] frame_cnt;

    logic       rst2_n, enable2, reseed2, ready2;
    logic       valid2, busy2, overrun2;
    logic [3:0] a2, b2;
    logic [7:0] frame_cnt2;

    int     n_checks = 0;
    int     n_err    = 0;
    frame_t exp_q[$];
    frame_t exp_q2[$];
    int     acc_cnt  = 0;
    int     acc_cnt2 = 0;

    logic [3:0] t2_a [6] = '{4'b1110, 4'b0111, 4'b1011, 4'b0101, 4'b1010, 4'b1101};
    logic [3:0] t2_b [6] = '{4'b1101, 4'b0110, 4'b1011, 4'b1101, 4'b1110, 4'b0111};

    always #5 clk = ~clk;

    lfsr_pair_stepper #(
        .TICK_DIV (4), .STEPS (4), .SEED_A (4'b1101), .SEED_B (4'b1010), .RELOAD (1'b1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .enable (enable), .reseed (reseed),
        .out_ready (out_ready), .out_valid (out_valid), .out_a (out_a), .out_b (out_b),
        .busy (busy), .overrun (overrun), .frame_cnt (frame_cnt)
    );

    lfsr_pair_stepper #(
        .TICK_DIV (4), .STEPS (1), .SEED_A (4'b1101), .SEED_B (4'b1010), .RELOAD (1'b0)
    ) dut2 (
        .clk (clk), .rst_n (rst2_n), .enable (enable2), .reseed (reseed2),
        .out_ready (ready2), .out_valid (valid2), .out_a (a2), .out_b (b2),
        .busy (busy2), .overrun (overrun2), .frame_cnt (frame_cnt2)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic frame_t mk(input logic [3:0] a, input logic [3:0] b);
        frame_t f;
        f.a = a;
        f.b = b;
        return f;
    endfunction

    task automatic tick_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard for the STEPS=4 instance.
    always @(negedge clk) begin
        frame_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb1_unexpected_frame", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_val("sb1_a", out_a, e.a);
                check_val("sb1_b", out_b, e.b);
            end
            acc_cnt++;
        end
    end

    // Scoreboard for the STEPS=1 instance.
    always @(negedge clk) begin
        frame_t e;
        if (rst2_n && valid2 && ready2) begin
            if (exp_q2.size() == 0) begin
                check_val("sb2_unexpected_frame", exp_q2.size(), 1);
            end else begin
                e = exp_q2.pop_front();
                check_val("sb2_a", a2, e.a);
                check_val("sb2_b", b2, e.b);
            end
            acc_cnt2++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  base;
        bit  saw_255;

        rst_n = 1'b0; enable = 1'b0; reseed = 1'b0; out_ready = 1'b1;
        rst2_n = 1'b0; enable2 = 1'b0; reseed2 = 1'b0; ready2 = 1'b1;
        tick_clk(3);

        // Reset values
        check_val("rst_valid", out_valid, 0);
        check_val("rst_a", out_a, 4'b1101);
        check_val("rst_b", out_b, 4'b1010);
        check_val("rst_busy", busy, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_frame_cnt", frame_cnt, 0);

        // 1: first frame latency and contents, RELOAD repeats the same frame
        repeat (3) exp_q.push_back(mk(4'b0101, 4'b1101));
        rst_n = 1'b1; enable = 1'b1;
        k = 0;
        while (!out_valid && k < 50) begin tick_clk(1); k++; end
        check_val("t1_latency", k, 8);
        tick_clk(1);
        check_val("t1_valid_pulse", out_valid, 0);
        check_val("t1_frame_cnt", frame_cnt, 1);
        k = 0;
        while (acc_cnt < 3 && k < 100) begin tick_clk(1); k++; end
        enable = 1'b0;
        check_val("t1_frames", acc_cnt, 3);
        check_val("t1_overrun", overrun, 1);

        // 3: backpressure holds frame; late tick sets overrun without a new frame
        reseed = 1'b1;
        tick_clk(1);
        reseed = 1'b0;
        check_val("t3_reseed_ovr", overrun, 0);
        check_val("t3_reseed_cnt", frame_cnt, 0);
        exp_q.push_back(mk(4'b0101, 4'b1101));
        out_ready = 1'b0; enable = 1'b1;
        k = 0;
        while (!busy && k < 20) begin tick_clk(1); k++; end
        enable = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin tick_clk(1); k++; end
        check_val("t3_valid", out_valid, 1);
        check_val("t3_no_ovr_yet", overrun, 0);
        for (int i = 0; i < 10; i++) begin
            tick_clk(1);
            check_val("t3_hold_valid", out_valid, 1);
            check_val("t3_hold_data", {out_a, out_b}, 8'h5D);
        end
        enable = 1'b1;
        k = 0;
        while (!overrun && k < 20) begin tick_clk(1); k++; end
        enable = 1'b0;
        check_val("t3_overrun", overrun, 1);
        check_val("t3_still_valid", out_valid, 1);
        check_val("t3_no_accept", frame_cnt, 0);
        out_ready = 1'b1;
        tick_clk(1);
        check_val("t3_accepted_cnt", frame_cnt, 1);
        check_val("t3_after_valid", out_valid, 0);

        // 4: reseed during SHIFT abandons the frame
        enable = 1'b1;
        k = 0;
        while (!busy && k < 20) begin tick_clk(1); k++; end
        tick_clk(1);
        check_val("t4_in_shift", busy, 1);
        reseed = 1'b1; enable = 1'b0;
        tick_clk(1);
        reseed = 1'b0;
        check_val("t4_busy", busy, 0);
        check_val("t4_valid", out_valid, 0);
        check_val("t4_frame_cnt", frame_cnt, 0);
        check_val("t4_overrun", overrun, 0);
        check_val("t4_a", out_a, 4'b1101);
        check_val("t4_b", out_b, 4'b1010);
        base = acc_cnt;
        tick_clk(8);
        check_val("t4_no_frame", acc_cnt - base, 0);

        // 5: enable low for 7 clocks at count 2 delays the tick by 7
        exp_q.push_back(mk(4'b0101, 4'b1101));
        enable = 1'b1;
        tick_clk(2);
        enable = 1'b0;
        tick_clk(7);
        enable = 1'b1;
        k = 7;
        while (!busy && k < 40) begin tick_clk(1); k++; end
        check_val("t5_tick_delay", k, 9);
        enable = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin tick_clk(1); k++; end
        check_val("t5_shift_len", k, 4);
        tick_clk(1);
        check_val("t5_frame_cnt", frame_cnt, 1);

        // 6: 256 frames wrap frame_cnt
        reseed = 1'b1;
        tick_clk(1);
        reseed = 1'b0;
        repeat (256) exp_q.push_back(mk(4'b0101, 4'b1101));
        base = acc_cnt;
        saw_255 = 1'b0;
        enable = 1'b1;
        k = 0;
        while (acc_cnt < base + 256 && k < 3000) begin
            tick_clk(1);
            if (frame_cnt == 8'd255) saw_255 = 1'b1;
            k++;
        end
        enable = 1'b0;
        check_val("t6_frames", acc_cnt - base, 256);
        check_val("t6_saw_255", saw_255, 1);
        tick_clk(1);
        check_val("t6_wrap", frame_cnt, 0);

        // 6b: async reset mid-PRESENT
        out_ready = 1'b0; enable = 1'b1;
        k = 0;
        while (!out_valid && k < 20) begin tick_clk(1); k++; end
        enable = 1'b0;
        check_val("t6_pre_valid", out_valid, 1);
        check_val("t6_pre_ovr", overrun, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_arst_valid", out_valid, 0);
        check_val("t6_arst_busy", busy, 0);
        check_val("t6_arst_a", out_a, 4'b1101);
        check_val("t6_arst_b", out_b, 4'b1010);
        check_val("t6_arst_ovr", overrun, 0);
        check_val("t6_arst_cnt", frame_cnt, 0);
        tick_clk(2);
        rst_n = 1'b1; out_ready = 1'b1;

        // 2: STEPS=1, RELOAD=0 walks the A sequence
        for (int i = 0; i < 6; i++) exp_q2.push_back(mk(t2_a[i], t2_b[i]));
        rst2_n = 1'b1; enable2 = 1'b1;
        k = 0;
        while (acc_cnt2 < 6 && k < 200) begin tick_clk(1); k++; end
        enable2 = 1'b0;
        check_val("t2_frames", acc_cnt2, 6);
        tick_clk(2);
        check_val("t2_frame_cnt", frame_cnt2, 6);
        check_val("t2_overrun", overrun2, 0);

        check_val("sb1_drained", exp_q.size(), 0);
        check_val("sb2_drained", exp_q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
